bp_be_ctxt_switch_ctrl: RTL
===========================

// Module: bp_be_ctxt_switch_ctrl
// PURPOSE
//  Responder for CSR-initiated context-switch requests raised by the calculator on a CTXT CSR write.
//  Sequences each switch: stall issue, drain, save outgoing context, select new thread, restore, redirect FE.
//  Sits in the BE between the calculator, bp_be_context_storage and the director.
//  Owns the architectural current-thread ID.
// PARAMETERS
//  num_threads_p      2   hardware thread contexts (>=2)
//  thread_id_width_p  1   `BSG_SAFE_CLOG2(num_threads_p)
//  vaddr_width_p      39  PC width
//  asid_width_p       10  ASID width
// PORTS
//  clk_i                   in   1      clock
//  reset_i                 in   1      synchronous, active-high reset
//  ctxt_req_v_i            in   1      switch request; coincides with commit of the CTXT CSR write
//  ctxt_req_tid_i          in   tid_w  target thread
//  ctxt_req_ready_and_o    out  1      request accepted when v & ready
//  commit_npc_i            in   vaddr  next PC of the committing CSR instruction
//  commit_priv_mode_i      in   2      current privilege mode
//  commit_translation_en_i in   1      current translation enable
//  commit_asid_i           in   asid   current ASID
//  pipe_idle_i             in   1      no mem/idiv/fdiv busy and no late writeback pending
//  suspend_iss_o           out  1      director must suppress issue
//  thread_id_o             out  tid_w  current thread; drives context_storage read index
//  save_v_o                out  1      one-cycle write strobe to context_storage
//  save_tid_o              out  tid_w  thread being saved
//  save_npc_o / save_priv_mode_o / save_translation_en_o / save_asid_o  out  ctxt fields to write
//  restore_npc_i / restore_priv_mode_i / restore_translation_en_i / restore_asid_i  in  context_storage read data
//  redirect_v_o            out  1      FE redirect/state-reset request to director
//  redirect_npc_o / redirect_priv_mode_o / redirect_translation_en_o / redirect_asid_o  out  restored ctxt
//  redirect_yumi_i         in   1      director consumed redirect
//  busy_o                  out  1      state != e_run
// BEHAVIOUR
//  Reset: state=e_run, thread_id_o=0, all _v_o=0, suspend_iss_o=0, busy_o=0, ctxt_req_ready_and_o=0 during reset.
//  e_run: ready_and_o=1. On handshake with tid==thread_id_o or tid>=num_threads_p: no-op, stay e_run.
//   Else latch target tid and commit_* fields into saved-ctxt reg; -> e_drain next cycle.
//  e_drain: suspend_iss_o=1, ready=0; wait for pipe_idle_i=1 (min 1 cycle) -> e_save.
//  e_save: save_v_o=1 exactly one cycle, save_tid_o=old thread, fields=latched ctxt -> e_restore.
//  e_restore: thread_id_o<=target; restore_* read combinationally next cycle -> e_redirect.
//  e_redirect: redirect_v_o=1, fields registered from restore_* on entry, held stable until redirect_yumi_i;
//   on yumi -> e_run, suspend_iss_o drops same cycle.
//  suspend_iss_o=1 in every state except e_run.
//  Minimum latency request->redirect_v_o: 4 cycles (pipe_idle_i already high).
//  Requests arriving while busy are not accepted (ready=0); the initiator holds them.
//  Simultaneous reset and request: reset wins, request dropped.
//  Reset mid-switch: abort, no save_v_o issued, thread 0, e_run.
//  thread_id_o changes only in e_restore, never mid-drain.
// CONFIGURATION
//  BP_BE_CTXT_SWITCH_STATS_EN defined: adds outputs switch_count_o[31:0] (completed switches, wraps at 2^32)
//   and drain_cycles_o[31:0] (sum of cycles spent in e_drain, saturating); both cleared by reset.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  bp_be_pkg: enum bp_be_ctxt_state_e {e_run, e_drain, e_save, e_restore, e_redirect}.
//  bp_be_defines.svh: `declare_bp_be_ctxt_s(vaddr_width_p, asid_width_p) struct {npc, priv_mode, translation_en, asid},
//   shared with bp_be_context_storage.
//  Single module; stats counters inline (bsg_counter_clear_up), no further sub-module.
// TESTING
//  1) tid 0 running, req tid=1, npc=0x8000_1000, pipe_idle=1 -> save_v (tid0, npc 0x8000_1000) cycle+2;
//     redirect_v cycle+4 with thread1 npc; thread_id_o=1.
//  2) req tid=thread_id_o -> ready=1, no state change, no save_v/redirect_v, suspend_iss_o=0.
//  3) pipe_idle_i low 10 cycles after accept -> suspend_iss_o high throughout, save_v only after idle;
//     drain_cycles_o=10 with STATS_EN.
//  4) redirect_yumi_i withheld 5 cycles -> redirect_v_o and fields stable; second request ignored (ready=0) until e_run.
//  5) reset asserted in e_save/e_redirect -> next cycle thread_id_o=0, all _v_o=0, busy_o=0.
//  6) num_threads_p=3, req tid=3 -> no-op; 3 legal switches 0->1->2->0 -> switch_count_o=3.

Source files
------------

// File: rtl/bp_be_ctxt_switch_ctrl_pkg.sv
// Shared types and helpers for the back-end context-switch controller.
// Holds the switch sequencer state encoding and a saturating counter helper
// used by the optional statistics logic.
package bp_be_ctxt_switch_ctrl_pkg;

    typedef enum logic [2:0] {
        e_run,
        e_drain,
        e_save,
        e_restore,
        e_redirect
    } bp_be_ctxt_state_e;

    localparam int priv_mode_width_gp = 2;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/bp_be_ctxt_switch_ctrl.sv
// Context-switch sequencer for the back end.
// Accepts CSR-initiated switch requests, stalls issue, waits for the pipe to
// drain, saves the outgoing context, selects the new thread, restores its
// context and hands a redirect to the director. Owns the current thread ID.
// Optional statistics outputs are enabled with BP_BE_CTXT_SWITCH_STATS_EN.
module bp_be_ctxt_switch_ctrl
    import bp_be_ctxt_switch_ctrl_pkg::*;
#(
    parameter int num_threads_p     = 2,
    parameter int thread_id_width_p = (num_threads_p > 1) ? $clog2(num_threads_p) : 1,
    parameter int vaddr_width_p     = 39,
    parameter int asid_width_p      = 10
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic                         ctxt_req_v_i,
    input  logic [thread_id_width_p-1:0] ctxt_req_tid_i,
    output logic                         ctxt_req_ready_and_o,

    input  logic [vaddr_width_p-1:0]     commit_npc_i,
    input  logic [1:0]                   commit_priv_mode_i,
    input  logic                         commit_translation_en_i,
    input  logic [asid_width_p-1:0]      commit_asid_i,

    input  logic                         pipe_idle_i,
    output logic                         suspend_iss_o,
    output logic [thread_id_width_p-1:0] thread_id_o,

    output logic                         save_v_o,
    output logic [thread_id_width_p-1:0] save_tid_o,
    output logic [vaddr_width_p-1:0]     save_npc_o,
    output logic [1:0]                   save_priv_mode_o,
    output logic                         save_translation_en_o,
    output logic [asid_width_p-1:0]      save_asid_o,

    input  logic [vaddr_width_p-1:0]     restore_npc_i,
    input  logic [1:0]                   restore_priv_mode_i,
    input  logic                         restore_translation_en_i,
    input  logic [asid_width_p-1:0]      restore_asid_i,

    output logic                         redirect_v_o,
    output logic [vaddr_width_p-1:0]     redirect_npc_o,
    output logic [1:0]                   redirect_priv_mode_o,
    output logic                         redirect_translation_en_o,
    output logic [asid_width_p-1:0]      redirect_asid_o,
    input  logic                         redirect_yumi_i,

    output logic                         busy_o
`ifdef BP_BE_CTXT_SWITCH_STATS_EN
    ,
    output logic [31:0]                  switch_count_o,
    output logic [31:0]                  drain_cycles_o
`endif
);

    typedef struct packed {
        logic [vaddr_width_p-1:0]      npc;
        logic [priv_mode_width_gp-1:0] priv_mode;
        logic                          translation_en;
        logic [asid_width_p-1:0]       asid;
    } ctxt_s;

    localparam logic [31:0] num_threads_lp = 32'(num_threads_p);

    bp_be_ctxt_state_e              state_r, state_n;
    logic [thread_id_width_p-1:0]   thread_id_r;
    logic [thread_id_width_p-1:0]   target_tid_r;
    ctxt_s                          saved_ctxt_r;
    ctxt_s                          redirect_ctxt_r;
    ctxt_s                          commit_ctxt;
    ctxt_s                          restore_ctxt;
    logic                           req_legal;
    logic                           accept;

    assign commit_ctxt  = '{npc: commit_npc_i, priv_mode: commit_priv_mode_i,
                            translation_en: commit_translation_en_i, asid: commit_asid_i};
    assign restore_ctxt = '{npc: restore_npc_i, priv_mode: restore_priv_mode_i,
                            translation_en: restore_translation_en_i, asid: restore_asid_i};

    // A request only starts a switch if it names a real thread other than the current one
    assign req_legal = (32'(ctxt_req_tid_i) < num_threads_lp) && (ctxt_req_tid_i != thread_id_r);
    assign accept    = ctxt_req_v_i && ctxt_req_ready_and_o && req_legal;

    // Next-state sequencing and handshake/strobe outputs; strobes are masked while reset is high
    always_comb begin
        state_n              = state_r;
        ctxt_req_ready_and_o = 1'b0;
        save_v_o             = 1'b0;
        redirect_v_o         = 1'b0;
        case (state_r)
            e_run: begin
                ctxt_req_ready_and_o = !reset_i;
                if (ctxt_req_v_i && req_legal)
                    state_n = e_drain;
            end
            e_drain: begin
                if (pipe_idle_i)
                    state_n = e_save;
            end
            e_save: begin
                save_v_o = !reset_i;
                state_n  = e_restore;
            end
            e_restore: begin
                state_n = e_redirect;
            end
            e_redirect: begin
                redirect_v_o = !reset_i;
                if (redirect_yumi_i)
                    state_n = e_run;
            end
            default: state_n = e_run;
        endcase
    end

    // State, current thread and captured contexts; reset aborts any switch in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r         <= e_run;
            thread_id_r     <= '0;
            target_tid_r    <= '0;
            saved_ctxt_r    <= '0;
            redirect_ctxt_r <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                target_tid_r <= ctxt_req_tid_i;
                saved_ctxt_r <= commit_ctxt;
            end
            if (state_r == e_save)
                thread_id_r <= target_tid_r;
            if (state_r == e_restore)
                redirect_ctxt_r <= restore_ctxt;
        end
    end

    assign suspend_iss_o = (state_r != e_run);
    assign busy_o        = (state_r != e_run);
    assign thread_id_o   = thread_id_r;

    assign save_tid_o            = thread_id_r;
    assign save_npc_o            = saved_ctxt_r.npc;
    assign save_priv_mode_o      = saved_ctxt_r.priv_mode;
    assign save_translation_en_o = saved_ctxt_r.translation_en;
    assign save_asid_o           = saved_ctxt_r.asid;

    assign redirect_npc_o            = redirect_ctxt_r.npc;
    assign redirect_priv_mode_o      = redirect_ctxt_r.priv_mode;
    assign redirect_translation_en_o = redirect_ctxt_r.translation_en;
    assign redirect_asid_o           = redirect_ctxt_r.asid;

`ifdef BP_BE_CTXT_SWITCH_STATS_EN
    logic [31:0] switch_count_r;
    logic [31:0] drain_cycles_r;

    // Completed-switch count wraps; drain-cycle total saturates
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            switch_count_r <= '0;
            drain_cycles_r <= '0;
        end else begin
            if (state_r == e_redirect && redirect_yumi_i)
                switch_count_r <= switch_count_r + 32'd1;
            if (state_r == e_drain)
                drain_cycles_r <= sat_inc32(drain_cycles_r);
        end
    end

    assign switch_count_o = switch_count_r;
    assign drain_cycles_o = drain_cycles_r;
`endif

endmodule
